// File: rtl/awg_pkg.sv
// Shared types, register map and reset defaults for the multi-channel waveform generator.
package awg_pkg;

  typedef enum logic [1:0] {
    WaveSquare = 2'd0,
    WaveSaw    = 2'd1,
    WaveTri    = 2'd2,
    WaveDc     = 2'd3
  } wave_e;

  localparam logic [2:0] AddrCtrl   = 3'd0;
  localparam logic [2:0] AddrFreq   = 3'd1;
  localparam logic [2:0] AddrAmp    = 3'd2;
  localparam logic [2:0] AddrOffset = 3'd3;
  localparam logic [2:0] AddrPhase  = 3'd4;

  localparam int unsigned CtrlEnBit = 2;

  // Width-dependent defaults (amp all-ones, freq/offset/phase zero) live in the channel.
  localparam logic  ResetEn   = 1'b0;
  localparam wave_e ResetWave = WaveSquare;

endpackage

// File: rtl/awg_channel.sv
// One generator channel: shadow/active config, phase accumulator, raw shape, S1/S2 pipeline.
// With AWG_PHASE_SYNC_EN defined, a commit also clears the accumulator.
module awg_channel
  import awg_pkg::*;
#(
  parameter int unsigned DATA_W  = 10,
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned FREQ_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              we,
  input  logic [2:0]        addr,
  input  logic [FREQ_W-1:0] wdata,
  input  logic              commit,
  output logic [DATA_W-1:0] sample
);

  logic              sh_en_q, sh_en_d, act_en_q;
  wave_e             sh_wave_q, sh_wave_d, act_wave_q;
  logic [FREQ_W-1:0] sh_freq_q, sh_freq_d, act_freq_q;
  logic [DATA_W-1:0] sh_amp_q, sh_amp_d, act_amp_q;
  logic [DATA_W-1:0] sh_off_q, sh_off_d, act_off_q;
  logic [DATA_W-1:0] sh_phase_q, sh_phase_d, act_phase_q;

  logic [PHASE_W-1:0] acc_q, acc_d, phase_sum;
  logic [DATA_W-1:0]  p, t, raw;

  logic              s1_valid_q, s1_en_q;
  logic [DATA_W-1:0] s1_raw_q, s1_amp_q, s1_off_q;

  logic [DATA_W:0]   amp_p1, sum;
  logic [2*DATA_W:0] prod;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              unused_bits;

  always_comb begin
    sh_en_d    = sh_en_q;
    sh_wave_d  = sh_wave_q;
    sh_freq_d  = sh_freq_q;
    sh_amp_d   = sh_amp_q;
    sh_off_d   = sh_off_q;
    sh_phase_d = sh_phase_q;
    if (we) begin
      case (addr)
        AddrCtrl: begin
          sh_en_d   = wdata[CtrlEnBit];
          sh_wave_d = wave_e'(wdata[1:0]);
        end
        AddrFreq:   sh_freq_d  = wdata;
        AddrAmp:    sh_amp_d   = wdata[DATA_W-1:0];
        AddrOffset: sh_off_d   = wdata[DATA_W-1:0];
        AddrPhase:  sh_phase_d = wdata[DATA_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (tick) begin
      acc_d = act_en_q ? acc_q + PHASE_W'(act_freq_q) : '0;
    end
`ifdef AWG_PHASE_SYNC_EN
    if (commit) begin
      acc_d = '0;
    end
`endif
  end

  // Phase uses the pre-increment accumulator.
  always_comb begin
    phase_sum = acc_q + (PHASE_W'(act_phase_q) << (PHASE_W - DATA_W));
    p         = phase_sum[PHASE_W-1 -: DATA_W];
    t         = {p[DATA_W-2:0], 1'b0};
    raw       = '0;
    unique case (act_wave_q)
      WaveSquare: raw = p[DATA_W-1] ? '1 : '0;
      WaveSaw:    raw = p;
      WaveTri:    raw = p[DATA_W-1] ? ~t : t;
      WaveDc:     raw = '1;
    endcase
  end

  always_comb begin
    amp_p1      = {1'b0, s1_amp_q} + (DATA_W + 1)'(1);
    prod        = (2 * DATA_W + 1)'(s1_raw_q) * (2 * DATA_W + 1)'(amp_p1);
    sum         = {1'b0, prod[2*DATA_W-1:DATA_W]} + {1'b0, s1_off_q};
    sample_d    = '0;
    if (s1_en_q) begin
      sample_d = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
    end
    unused_bits = ^{prod[2*DATA_W], prod[DATA_W-1:0], phase_sum[PHASE_W-DATA_W-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_en_q     <= ResetEn;
      sh_wave_q   <= ResetWave;
      sh_freq_q   <= '0;
      sh_amp_q    <= '1;
      sh_off_q    <= '0;
      sh_phase_q  <= '0;
      act_en_q    <= ResetEn;
      act_wave_q  <= ResetWave;
      act_freq_q  <= '0;
      act_amp_q   <= '1;
      act_off_q   <= '0;
      act_phase_q <= '0;
      acc_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_en_q     <= 1'b0;
      s1_raw_q    <= '0;
      s1_amp_q    <= '0;
      s1_off_q    <= '0;
      sample_q    <= '0;
    end else begin
      sh_en_q    <= sh_en_d;
      sh_wave_q  <= sh_wave_d;
      sh_freq_q  <= sh_freq_d;
      sh_amp_q   <= sh_amp_d;
      sh_off_q   <= sh_off_d;
      sh_phase_q <= sh_phase_d;
      // Commit takes the post-write shadow so a same-cycle write is included.
      if (commit) begin
        act_en_q    <= sh_en_d;
        act_wave_q  <= sh_wave_d;
        act_freq_q  <= sh_freq_d;
        act_amp_q   <= sh_amp_d;
        act_off_q   <= sh_off_d;
        act_phase_q <= sh_phase_d;
      end
      acc_q      <= acc_d;
      s1_valid_q <= tick;
      if (tick) begin
        s1_en_q  <= act_en_q;
        s1_raw_q <= raw;
        s1_amp_q <= act_amp_q;
        s1_off_q <= act_off_q;
      end
      if (s1_valid_q) begin
        sample_q <= sample_d;
      end
    end
  end

  assign sample = sample_q;

endmodule

// File: rtl/awg_multi_wavegen.sv
// Multi-channel waveform generator top: sample divider, write decode, commit fan-out, packing.
// Optional AWG_PHASE_SYNC_EN makes every commit phase-align all channel accumulators.
module awg_multi_wavegen
  import awg_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DATA_W  = 10,
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned FREQ_W  = 16,
  parameter int unsigned CLK_DIV = 1,
  localparam int unsigned ChW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we_i,
  input  logic [ChW-1:0]           cfg_ch_i,
  input  logic [2:0]               cfg_addr_i,
  input  logic [FREQ_W-1:0]        cfg_wdata_i,
  input  logic                     cfg_commit_i,
  output logic [NUM_CH*DATA_W-1:0] sample_o,
  output logic                     sample_valid_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0] div_q, div_d;
  logic            tick, tick_q, valid_q;

  always_comb begin
    tick  = (div_q == DivW'(CLK_DIV - 1));
    div_d = tick ? '0 : div_q + DivW'(1);
  end

  // Valid trails the tick by the two pipeline stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick;
      valid_q <= tick_q;
    end
  end

  assign sample_valid_o = valid_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;
    assign ch_we = cfg_we_i && (cfg_ch_i == ChW'(i));

    awg_channel #(
      .DATA_W (DATA_W),
      .PHASE_W(PHASE_W),
      .FREQ_W (FREQ_W)
    ) u_channel (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .we    (ch_we),
      .addr  (cfg_addr_i),
      .wdata (cfg_wdata_i),
      .commit(cfg_commit_i),
      .sample(sample_o[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_awg_multi_wavegen.sv
// Self-checking bench for awg_multi_wavegen: vector table plus hand-written timing sequences.
module tb_awg_multi_wavegen;
  import awg_pkg::*;

  localparam int unsigned NumCh = 2;
  localparam int unsigned DataW = 10;
  localparam int unsigned FreqW = 16;
  localparam int unsigned OutW  = NumCh * DataW;
  localparam int unsigned NVec  = 11;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_we = 1'b0;
  logic [0:0]      cfg_ch = '0;
  logic [2:0]      cfg_addr = '0;
  logic [FreqW-1:0] cfg_wdata = '0;
  logic            cfg_commit = 1'b0;
  logic [OutW-1:0] sample;
  logic            sample_valid;

  always #5 clk = ~clk;

  awg_multi_wavegen #(
    .NUM_CH (NumCh),
    .DATA_W (DataW),
    .PHASE_W(24),
    .FREQ_W (FreqW),
    .CLK_DIV(1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_we_i      (cfg_we),
    .cfg_ch_i      (cfg_ch),
    .cfg_addr_i    (cfg_addr),
    .cfg_wdata_i   (cfg_wdata),
    .cfg_commit_i  (cfg_commit),
    .sample_o      (sample),
    .sample_valid_o(sample_valid)
  );

  typedef struct {
    logic [OutW-1:0] exp;
    logic [OutW-1:0] mask;
  } sb_t;

  typedef struct {
    int    ch;
    wave_e wave;
    int    amp;
    int    off;
    int    ph;
    int    e0;
    int    e1;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[NVec];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [OutW-1:0] act,
                       input logic [OutW-1:0] exp, input logic [OutW-1:0] mask);
    tests++;
    if ((act & mask) !== (exp & mask)) begin
      fails++;
      $display("FAIL %s: got %h expected %h (mask %h)", name, act & mask, exp & mask, mask);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic push_ch(input int ch, input int v);
    sb_t e;
    e.exp  = OutW'(v) << (ch * DataW);
    e.mask = OutW'((1 << DataW) - 1) << (ch * DataW);
    sb_q.push_back(e);
  endtask

  task automatic push_both(input int v0, input int v1);
    sb_t e;
    e.exp  = (OutW'(v1) << DataW) | OutW'(v0);
    e.mask = '1;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string name);
    sb_t e;
    check_bit({name, "_valid"}, sample_valid, 1'b1);
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty, got %h", name, sample);
    end else begin
      e = sb_q.pop_front();
      check(name, sample, e.exp, e.mask);
    end
  endtask

  // Skip the pre-commit sample(s), then compare one popped entry per cycle.
  task automatic drain(input int skip, input int n, input string name);
    for (int i = 0; i < skip + n; i++) begin
      @(negedge clk);
      if (i >= skip) pop_check(name);
    end
  endtask

  task automatic cfg(input int ch, input logic [2:0] addr, input int data, input bit commit);
    cfg_we     = 1'b1;
    cfg_ch     = 1'(ch);
    cfg_addr   = addr;
    cfg_wdata  = FreqW'(data);
    cfg_commit = commit;
    @(negedge clk);
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  // Disable and clear the channel, load its parameters, then enable with a single commit.
  task automatic setup_ch(input int ch, input wave_e wave, input int freq, input int amp,
                          input int off, input int ph);
    cfg(ch, AddrCtrl, 0, 1'b1);
    repeat (2) @(negedge clk);
    cfg(ch, AddrFreq, freq, 1'b0);
    cfg(ch, AddrAmp, amp, 1'b0);
    cfg(ch, AddrOffset, off, 1'b0);
    cfg(ch, AddrPhase, ph, 1'b0);
    cfg(ch, AddrCtrl, 4 | int'(wave), 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{ch: 0, wave: WaveSaw,    amp: 1023, off: 0,    ph: 0,    e0: 0,    e1: 1};
    vecs[1]  = '{ch: 0, wave: WaveSaw,    amp: 1023, off: 0,    ph: 1023, e0: 1023, e1: 0};
    vecs[2]  = '{ch: 1, wave: WaveSaw,    amp: 511,  off: 600,  ph: 1023, e0: 1023, e1: 600};
    vecs[3]  = '{ch: 0, wave: WaveTri,    amp: 1023, off: 0,    ph: 255,  e0: 510,  e1: 512};
    vecs[4]  = '{ch: 0, wave: WaveTri,    amp: 1023, off: 0,    ph: 512,  e0: 1023, e1: 1021};
    vecs[5]  = '{ch: 0, wave: WaveTri,    amp: 1023, off: 0,    ph: 768,  e0: 511,  e1: 509};
    vecs[6]  = '{ch: 1, wave: WaveSquare, amp: 1023, off: 0,    ph: 511,  e0: 0,    e1: 1023};
    vecs[7]  = '{ch: 0, wave: WaveDc,     amp: 511,  off: 100,  ph: 0,    e0: 611,  e1: 611};
    vecs[8]  = '{ch: 1, wave: WaveSaw,    amp: 0,    off: 5,    ph: 1000, e0: 5,    e1: 5};
    vecs[9]  = '{ch: 0, wave: WaveSaw,    amp: 1023, off: 1023, ph: 0,    e0: 1023, e1: 1023};
    vecs[10] = '{ch: 0, wave: WaveSaw,    amp: 255,  off: 0,    ph: 800,  e0: 200,  e1: 200};

    // Reset state and first-tick latency.
    repeat (2) @(negedge clk);
    check("reset_sample", sample, '0, '1);
    check_bit("reset_valid", sample_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("first_valid_latency", sample_valid, 1'b0);
    for (int i = 0; i < 5; i++) push_both(0, 0);
    drain(0, 5, "idle_zero");

    // Freq write without commit is invisible; a write with commit steps by 2 from the next tick.
    setup_ch(0, WaveSaw, 16384, 1023, 0, 0);
    for (int j = 2; j <= 11; j++) push_ch(0, (j <= 9) ? j - 2 : 7 + 2 * (j - 9));
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      cfg_we     = 1'b0;
      cfg_commit = 1'b0;
      if (j >= 2) pop_check("freq_commit");
      if (j == 3 || j == 6) begin
        cfg_we     = 1'b1;
        cfg_ch     = 1'b0;
        cfg_addr   = AddrFreq;
        cfg_wdata  = FreqW'(32768);
        cfg_commit = (j == 6);
      end
    end

    // Both channels committed together from a common cleared state.
    cfg(0, AddrCtrl, 0, 1'b0);
    cfg(1, AddrCtrl, 0, 1'b1);
    repeat (2) @(negedge clk);
    for (int ch = 0; ch < 2; ch++) begin
      cfg(ch, AddrFreq, 16384, 1'b0);
      cfg(ch, AddrAmp, 1023, 1'b0);
      cfg(ch, AddrOffset, 0, 1'b0);
      cfg(ch, AddrPhase, ch * 256, 1'b0);
    end
    cfg(0, AddrCtrl, 4 | int'(WaveSaw), 1'b0);
    cfg(1, AddrCtrl, 4 | int'(WaveSaw), 1'b1);
    for (int k = 0; k < 8; k++) push_both(k, (k + 256) % 1024);
    drain(1, 8, "aligned_pair");

`ifdef AWG_PHASE_SYNC_EN
    // Channels drift apart in time, then a bare commit re-aligns both accumulators.
    repeat (37) @(negedge clk);
    cfg(1, AddrPhase, 256, 1'b1);
    for (int k = 0; k < 8; k++) push_both(k, (k + 256) % 1024);
    drain(1, 8, "phase_sync");
`endif

    for (int i = 0; i < NVec; i++) begin
      setup_ch(vecs[i].ch, vecs[i].wave, 16384, vecs[i].amp, vecs[i].off, vecs[i].ph);
      push_ch(vecs[i].ch, vecs[i].e0);
      push_ch(vecs[i].ch, vecs[i].e1);
      drain(1, 2, $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-stream clears outputs at once and restores defaults.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_sample", sample, '0, '1);
    check_bit("midreset_valid", sample_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push_both(0, 0);
    drain(1, 4, "post_reset");
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    for (int i = 0; i < 3; i++) push_both(0, 0);
    drain(1, 3, "post_reset_commit");

    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
